// File: rtl/snn_decode_pkg.sv
// Shared types and width helpers for the spike-rate decoder.
// The result struct uses fixed maximum field widths; the top level narrows them to its parameters.
package snn_decode_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        RESOLVE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int RES_IDX_W = 8;
    localparam int RES_CNT_W = 32;

    typedef struct packed {
        logic [RES_IDX_W-1:0] winner;
        logic [RES_CNT_W-1:0] count;
        logic                 none;
    } result_t;

    // One extra code point so that T_WINDOW itself can mean "no spike yet".
    function automatic int time_width(input int t_window);
        return $clog2(t_window + 1);
    endfunction

    function automatic int idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/spike_channel_counter.sv
// One channel's saturating spike count and first-spike time within a decode window.
module spike_channel_counter #(
    parameter int CNT_W    = 8,
    parameter int TIME_W   = 8,
    parameter int T_WINDOW = 250
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample,
    input  logic              spike,
    input  logic [TIME_W-1:0] t_now,
    input  logic              clear,
    output logic [CNT_W-1:0]  count,
    output logic [TIME_W-1:0] first_time
);

    localparam logic [TIME_W-1:0] NO_SPIKE = TIME_W'(T_WINDOW);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [TIME_W-1:0] first_q, first_d;

    always_comb begin
        count_d = count_q;
        first_d = first_q;
        if (clear) begin
            count_d = '0;
            first_d = NO_SPIKE;
        end else if (sample && spike) begin
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + 1'b1;
            end
            if (first_q == NO_SPIKE) begin
                first_d = t_now;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            first_q <= NO_SPIKE;
        end else begin
            count_q <= count_d;
            first_q <= first_d;
        end
    end

    assign count      = count_q;
    assign first_time = first_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts output-neuron spikes over a window, picks a winner one channel per cycle,
// and holds the classification on a valid/ready port until it is accepted.
module spike_rate_decoder
    import snn_decode_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int T_WINDOW = 250,
    parameter int CNT_W    = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [NUM_CH-1:0]                spike_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [idx_width(NUM_CH)-1:0]     out_winner,
    output logic [CNT_W-1:0]                 out_count,
    output logic [NUM_CH*CNT_W-1:0]          out_counts,
    output logic                             out_none,
    output logic                             drop_flag
);

    localparam int TIME_W = time_width(T_WINDOW);
    localparam int IDX_W  = idx_width(NUM_CH);
    localparam logic [TIME_W-1:0] T_LAST   = TIME_W'(T_WINDOW - 1);
    localparam logic [TIME_W-1:0] NO_SPIKE = TIME_W'(T_WINDOW);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CH - 1);

    state_t                    state_q, state_d;
    logic [TIME_W-1:0]         t_q, t_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          best_idx_q, best_idx_d;
    logic [CNT_W-1:0]          best_cnt_q, best_cnt_d;
    logic [TIME_W-1:0]         best_time_q, best_time_d;
    logic                      valid_q, valid_d;
    logic                      drop_q, drop_d;
    result_t                   res_q, res_d;
    logic [NUM_CH*CNT_W-1:0]   counts_q, counts_d;

    logic                      sample, clear, take;
    logic [CNT_W-1:0]          ch_count [NUM_CH];
    logic [TIME_W-1:0]         ch_time  [NUM_CH];
    logic [NUM_CH*CNT_W-1:0]   counts_flat;
    logic [CNT_W-1:0]          cur_cnt, win_cnt;
    logic [TIME_W-1:0]         cur_time;
    logic [IDX_W-1:0]          win_idx;

    assign sample = (state_q == COLLECT) && en;
    assign clear  = (state_q == HOLD) && valid_q && out_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        spike_channel_counter #(
            .CNT_W   (CNT_W),
            .TIME_W  (TIME_W),
            .T_WINDOW(T_WINDOW)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .sample    (sample),
            .spike     (spike_in[i]),
            .t_now     (t_q),
            .clear     (clear),
            .count     (ch_count[i]),
            .first_time(ch_time[i])
        );
        assign counts_flat[i*CNT_W +: CNT_W] = ch_count[i];
    end

    // Channel 0 seeds the running best; later channels must strictly beat it to take over.
    always_comb begin
        cur_cnt  = ch_count[idx_q];
        cur_time = ch_time[idx_q];
        take     = (idx_q == '0) || (cur_cnt > best_cnt_q) ||
                   ((cur_cnt == best_cnt_q) && (cur_time < best_time_q));
        win_idx  = take ? idx_q : best_idx_q;
        win_cnt  = take ? cur_cnt : best_cnt_q;
    end

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        idx_d       = idx_q;
        best_idx_d  = best_idx_q;
        best_cnt_d  = best_cnt_q;
        best_time_d = best_time_q;
        valid_d     = valid_q;
        res_d       = res_q;
        counts_d    = counts_q;
        drop_d      = drop_q | ((state_q != COLLECT) && (|spike_in));

        unique case (state_q)
            COLLECT: begin
                if (en) begin
                    if (t_q == T_LAST) begin
                        t_d     = '0;
                        idx_d   = '0;
                        state_d = RESOLVE;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            RESOLVE: begin
                best_idx_d  = win_idx;
                best_cnt_d  = win_cnt;
                best_time_d = take ? cur_time : best_time_q;
                if (idx_q == IDX_LAST) begin
                    state_d      = HOLD;
                    valid_d      = 1'b1;
                    res_d.winner = RES_IDX_W'(win_idx);
                    res_d.count  = RES_CNT_W'(win_cnt);
                    res_d.none   = (win_cnt == '0);
                    counts_d     = counts_flat;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            t_q         <= '0;
            idx_q       <= '0;
            best_idx_q  <= '0;
            best_cnt_q  <= '0;
            best_time_q <= NO_SPIKE;
            valid_q     <= 1'b0;
            drop_q      <= 1'b0;
            res_q       <= '0;
            counts_q    <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            idx_q       <= idx_d;
            best_idx_q  <= best_idx_d;
            best_cnt_q  <= best_cnt_d;
            best_time_q <= best_time_d;
            valid_q     <= valid_d;
            drop_q      <= drop_d;
            res_q       <= res_d;
            counts_q    <= counts_d;
        end
    end

    // Winner/count only fill the low bits of the wide shared struct fields.
    logic unused_res_bits;
    assign unused_res_bits = ^res_q;

    assign out_valid  = valid_q;
    assign out_winner = res_q.winner[IDX_W-1:0];
    assign out_count  = res_q.count[CNT_W-1:0];
    assign out_none   = res_q.none;
    assign out_counts = counts_q;
    assign drop_flag  = drop_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed self-checking bench: NUM_CH=4, T_WINDOW=10, plus a CNT_W=2 instance for saturation.
module tb_spike_rate_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, out_ready, out_valid, out_none, drop_flag;
    logic [3:0]  spike_in;
    logic [1:0]  out_winner;
    logic [7:0]  out_count;
    logic [31:0] out_counts;

    logic        en_s, ready_s, valid_s, none_s, drop_s;
    logic [3:0]  spike_s;
    logic [1:0]  winner_s, count_s;
    logic [7:0]  counts_s;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.NUM_CH(4), .T_WINDOW(10), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_winner(out_winner),
        .out_count(out_count), .out_counts(out_counts), .out_none(out_none),
        .drop_flag(drop_flag)
    );

    spike_rate_decoder #(.NUM_CH(4), .T_WINDOW(10), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en_s), .spike_in(spike_s),
        .out_valid(valid_s), .out_ready(ready_s), .out_winner(winner_s),
        .out_count(count_s), .out_counts(counts_s), .out_none(none_s),
        .drop_flag(drop_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ten enabled samples from a packed pattern (t-th nibble = spikes at t), then wait for valid.
    task automatic run_window(input logic [39:0] pats, output int lat);
        for (int t = 0; t < 10; t++) begin
            en = 1'b1;
            spike_in = pats[4*t +: 4];
            tick();
        end
        en = 1'b0;
        spike_in = 4'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) $display("[TB] FAIL %s_handshake: out_valid got %0b expected 0", name, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++;
        if ({out_valid, out_winner, out_count, out_none, drop_flag} !== 13'b0)
            $display("[TB] FAIL reset_outputs: got %h expected 0", {out_valid, out_winner, out_count, out_none, drop_flag});
        else pass_cnt++;
        total++;
        if (out_counts !== 32'h0) $display("[TB] FAIL reset_counts: got %h expected 0", out_counts);
        else pass_cnt++;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [39:0] p;
        int lat;
        p = '0;
        p[4*1 +: 4] = 4'b0100;
        p[4*3 +: 4] = 4'b0100;
        p[4*4 +: 4] = 4'b0001;
        p[4*5 +: 4] = 4'b0100;
        run_window(p, lat);
        total++;
        if (lat !== 4) $display("[TB] FAIL basic_latency: got %0d expected 4", lat);
        else pass_cnt++;
        total++;
        if (out_winner !== 2'd2) $display("[TB] FAIL basic_winner: got %0d expected 2", out_winner);
        else pass_cnt++;
        total++;
        if (out_count !== 8'd3) $display("[TB] FAIL basic_count: got %0d expected 3", out_count);
        else pass_cnt++;
        total++;
        if (out_counts !== 32'h0003_0001) $display("[TB] FAIL basic_counts: got %h expected 00030001", out_counts);
        else pass_cnt++;
        total++;
        if (out_none !== 1'b0) $display("[TB] FAIL basic_none: got %0b expected 0", out_none);
        else pass_cnt++;
        handshake("basic");
    endtask

    task automatic test_tie_break();
        logic [39:0] p;
        int lat;
        p = '0;
        p[4*0 +: 4] = 4'b1000;
        p[4*2 +: 4] = 4'b0010;
        p[4*5 +: 4] = 4'b1000;
        p[4*6 +: 4] = 4'b0010;
        run_window(p, lat);
        total++;
        if (out_winner !== 2'd3 || out_count !== 8'd2)
            $display("[TB] FAIL tie_first_time: winner/count got %0d/%0d expected 3/2", out_winner, out_count);
        else pass_cnt++;
        handshake("tie_a");
        p = '0;
        p[4*3 +: 4] = 4'b1010;
        p[4*7 +: 4] = 4'b1010;
        run_window(p, lat);
        total++;
        if (out_winner !== 2'd1 || out_count !== 8'd2)
            $display("[TB] FAIL tie_full: winner/count got %0d/%0d expected 1/2", out_winner, out_count);
        else pass_cnt++;
        handshake("tie_b");
    endtask

    task automatic test_none();
        int lat;
        run_window(40'h0, lat);
        total++;
        if ({out_none, out_winner, out_count} !== {1'b1, 2'd0, 8'd0})
            $display("[TB] FAIL none_result: none/winner/count got %0b/%0d/%0d expected 1/0/0", out_none, out_winner, out_count);
        else pass_cnt++;
        total++;
        if (out_counts !== 32'h0) $display("[TB] FAIL none_counts: got %h expected 0", out_counts);
        else pass_cnt++;
        handshake("none");
    endtask

    task automatic test_saturation();
        int lat;
        for (int t = 0; t < 10; t++) begin
            en_s = 1'b1;
            spike_s = 4'b0001;
            tick();
        end
        en_s = 1'b0;
        spike_s = 4'b0;
        lat = 0;
        while (!valid_s && lat < 20) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== 4) $display("[TB] FAIL sat_latency: got %0d expected 4", lat);
        else pass_cnt++;
        total++;
        if (count_s !== 2'd3 || winner_s !== 2'd0)
            $display("[TB] FAIL sat_result: count/winner got %0d/%0d expected 3/0", count_s, winner_s);
        else pass_cnt++;
        total++;
        if (counts_s !== 8'h03) $display("[TB] FAIL sat_counts: got %h expected 03", counts_s);
        else pass_cnt++;
    endtask

    task automatic test_enable_gating();
        int lat;
        int early;
        early = 0;
        for (int k = 0; k < 19; k++) begin
            en = (k % 2 == 0);
            if (k % 2 == 1) spike_in = 4'b0010;
            else if (k == 4) spike_in = 4'b0100;
            else spike_in = 4'b0000;
            tick();
            if (out_valid) early++;
        end
        en = 1'b0;
        spike_in = 4'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        total++;
        if (early !== 0 || lat !== 4)
            $display("[TB] FAIL gate_window_len: early valid cycles %0d latency %0d expected 0 and 4", early, lat);
        else pass_cnt++;
        total++;
        if (out_counts !== 32'h0001_0000 || out_winner !== 2'd2)
            $display("[TB] FAIL gate_counts: counts %h winner %0d expected 00010000 and 2", out_counts, out_winner);
        else pass_cnt++;
        total++;
        if (drop_flag !== 1'b0) $display("[TB] FAIL gate_drop: got %0b expected 0", drop_flag);
        else pass_cnt++;
        handshake("gate");
    endtask

    task automatic test_back_to_back();
        logic [39:0] p;
        int lat;
        p = '0;
        p[3:0] = 4'b0001;
        run_window(p, lat);
        for (int c = 0; c < 7; c++) begin
            spike_in = (c == 3) ? 4'b0001 : 4'b0000;
            tick();
            total++;
            if ({out_valid, out_winner, out_count, out_counts} !== {1'b1, 2'd0, 8'd1, 32'h1})
                $display("[TB] FAIL hold_stable: cycle %0d got %h expected %h", c,
                         {out_valid, out_winner, out_count, out_counts}, {1'b1, 2'd0, 8'd1, 32'h1});
            else pass_cnt++;
        end
        spike_in = 4'b0;
        total++;
        if (drop_flag !== 1'b1) $display("[TB] FAIL hold_drop: got %0b expected 1", drop_flag);
        else pass_cnt++;
        handshake("hold");
        p = '0;
        p[3:0] = 4'b1000;
        run_window(p, lat);
        total++;
        if (out_winner !== 2'd3 || out_counts !== 32'h0100_0000)
            $display("[TB] FAIL next_window_clear: winner %0d counts %h expected 3 and 01000000", out_winner, out_counts);
        else pass_cnt++;
        handshake("next");
    endtask

    task automatic test_async_reset();
        logic [39:0] p;
        int lat;
        for (int t = 0; t < 5; t++) begin
            en = 1'b1;
            spike_in = 4'b0010;
            tick();
        end
        en = 1'b0;
        spike_in = 4'b0;
        #3 rst = 1'b1;
        #1;
        total++;
        if ({drop_flag, out_counts} !== 33'b0)
            $display("[TB] FAIL async_rst_window: drop/counts got %0b/%h expected 0/0", drop_flag, out_counts);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        p = '0;
        p[3:0] = 4'b0010;
        run_window(p, lat);
        total++;
        if (out_winner !== 2'd1 || out_count !== 8'd1 || out_counts !== 32'h0000_0100)
            $display("[TB] FAIL async_after_window: winner %0d count %0d counts %h expected 1 1 00000100",
                     out_winner, out_count, out_counts);
        else pass_cnt++;
        #3 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_winner, out_count, out_counts} !== 43'b0)
            $display("[TB] FAIL async_rst_hold: got %h expected 0", {out_valid, out_winner, out_count, out_counts});
        else pass_cnt++;
        rst = 1'b0;
        tick();
        p = '0;
        p[4*9 +: 4] = 4'b1000;
        run_window(p, lat);
        total++;
        if (lat !== 4 || out_winner !== 2'd3 || out_count !== 8'd1)
            $display("[TB] FAIL async_after_hold: lat %0d winner %0d count %0d expected 4 3 1", lat, out_winner, out_count);
        else pass_cnt++;
        handshake("async");
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        spike_in = 4'b0;
        out_ready = 1'b0;
        en_s = 1'b0;
        spike_s = 4'b0;
        ready_s = 1'b0;
        test_reset();
        test_basic();
        test_tie_break();
        test_none();
        test_saturation();
        test_enable_gating();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

- Decodes the output-neuron spike trains into a classification result.
- Sits downstream of the excitatory output neurons: the other end of their `out_spike` interface.
- Over a window of `T_WINDOW` enabled cycles it counts spikes and records first-spike time per channel.
- It then resolves a winner and presents the result on a valid/ready port.

## Interface
- `NUM_CH`, 4: number of spike channels (output neurons), ≥2.
- `T_WINDOW`, 250: enabled cycles per decode window, ≥2.
- `CNT_W`, 8: per-channel spike-count width, saturating.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: time-step enable; window time advances only when high.
- `spike_in` in `NUM_CH`: one spike bit per channel, sampled on `en` cycles.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts result.
- `out_winner` out `clog2(NUM_CH)`: winning channel index.
- `out_count` out `CNT_W`: winner's spike count.
- `out_counts` out `NUM_CH*CNT_W`: all channel counts, channel 0 in LSBs.
- `out_none` out 1: no spike on any channel in the window.
- `drop_flag` out 1: sticky; a spike arrived while not collecting.

## Operation
- FSM states are COLLECT, RESOLVE and HOLD. Reset enters COLLECT.
- On reset all outputs are 0, all counters are 0, time t=0, and first-spike times are `T_WINDOW` (meaning "none").
- COLLECT, on `en` cycles only:
  - each channel with `spike_in[i]`=1 increments its count, saturating at 2^`CNT_W`−1;
  - if channel i has no first time yet, its first time becomes t;
  - t then increments.
- COLLECT with `en`=0: no state changes and spikes are ignored. They do not set `drop_flag`.
- Window end: the `en` cycle with t=`T_WINDOW`−1 is still sampled, then the FSM goes to RESOLVE and t clears.
- RESOLVE compares one channel per cycle, index 0..`NUM_CH`−1, against a running best:
  - higher count wins;
  - on equal count, the smaller first time wins;
  - on a full tie, the lower index wins (the incumbent is kept).
- After channel `NUM_CH`−1 the FSM enters HOLD and registers `out_valid`=1 and the result fields.
- `out_none`=1 iff all counts are 0. In that case `out_winner`=0 and `out_count`=0.
- HOLD: outputs are stable until `out_valid`&`out_ready`. On that edge:
  - `out_valid` goes to 0;
  - counts clear and first times reset;
  - the FSM returns to COLLECT with t=0.
- Any `spike_in` bit high during RESOLVE or HOLD, including the handshake cycle, is dropped and sets `drop_flag`. `en` is ignored in these states.
- `drop_flag` clears only on `rst`.
- A reset mid-window or mid-HOLD discards everything immediately, asynchronously.

## Timing
- The last window sample is edge E. Edges E+1..E+`NUM_CH` resolve channels 0..`NUM_CH`−1. `out_valid` is high after edge E+`NUM_CH`.
- `out_ready` may be held high permanently. Minimum HOLD is 1 cycle, and the next window's first sample is on the edge after the handshake.
- `out_valid` never deasserts without a handshake. Result fields never change while `out_valid`=1.
- `out_ready` is ignored when `out_valid`=0.
- Time width is `TIME_W`=clog2(`T_WINDOW`+1), so the value `T_WINDOW` is representable as "none".
- Counts and comparisons are unsigned.

## Structure
- Package `snn_decode_pkg` holds:
  - the state enum (COLLECT/RESOLVE/HOLD);
  - clog2-based width functions for `TIME_W` and the index width;
  - the shared result struct (winner, count, none).
- Sub-module `spike_channel_counter`, instantiated `NUM_CH` times:
  - one channel's saturating count and first-spike time;
  - inputs: sample strobe, spike bit, current t, clear.
- The top level holds the FSM, the window timer, the sequential comparator and the output registers.

## Test plan
Use `NUM_CH`=4 and `T_WINDOW`=10 unless stated otherwise.

- **Basic window:** `en`=1 throughout. Channel 2 spikes at t=1,3,5; channel 0 at t=4. Required:
  - `out_valid` 4 cycles after the t=9 sample;
  - winner=2, count=3;
  - `out_counts`={0,3,0,1} (channels 3..0);
  - `out_none`=0.
- **Tie-break:**
  - Channels 1 and 3 each spike twice; channel 3 first at t=0, channel 1 first at t=2. Required: winner=3.
  - Identical first times and counts on channels 1 and 3. Required: winner=1.
- **Saturation and none:**
  - With `CNT_W`=2, channel 0 spikes every cycle. Required: count=3, winner=0.
  - A window with no spikes. Required: `out_none`=1, winner=0, count=0.
- **Enable gating:** `en` toggles 1/0. Required:
  - the window spans 20 cycles;
  - spikes on `en`=0 cycles are not counted;
  - `drop_flag` stays 0.
- **Backpressure/drop:** hold `out_ready`=0 for 7 cycles in HOLD and pulse `spike_in`=0001. Required:
  - outputs stable throughout;
  - `drop_flag`=1;
  - after ready, the next window starts with zero counts.
- **Async reset:** assert `rst` at t=5 of a window and in HOLD. Required:
  - outputs drop to 0 without a clock edge;
  - the next window decodes correctly from t=0.
